fifo_seq_checker: RTL and testbench
===================================

// Module: fifo_seq_checker
// PURPOSE
//  Reader end of the FIFO stream interface. Pops words from a first-word-fall-through FIFO read port with an
//  optional pseudo-random pop throttle, and checks that they form a consecutive modulo-2^WIDTH counter sequence.
//  Keeps word and error statistics and captures the first mismatch. Sits on the out_* side of async_fifo, paired
//  with a counter source on the in_* side, for on-chip and bench stream integrity tests.
// PARAMETERS
//  WIDTH          8        data word width; expected sequence wraps modulo 2^WIDTH
//  CNT_WIDTH      32       width of word_count / error_count (both saturating)
//  THROTTLE_BITS  2        pop allowed only when lfsr[THROTTLE_BITS-1:0]==0 (rate ~2^-N); 0 = no throttle
//  LFSR_SEED      16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  clk           in   1          single clock, all logic posedge
//  rst           in   1          synchronous, active-high reset
//  enable        in   1          permits popping
//  resync        in   1          return to SYNC (re-acquire sequence); counters kept
//  clear         in   1          zero word_count, error_count, err_* capture
//  in_nempty     in   1          FIFO read port: data available
//  in_data       in   WIDTH      FIFO read port: head word, valid while in_nempty
//  in_pop        out  1          FIFO read port: consume head word this cycle
//  locked        out  1          sequence acquired (state CHECK)
//  word_count    out  CNT_WIDTH  words popped since reset/clear
//  error_count   out  CNT_WIDTH  sequence mismatches since reset/clear
//  err_valid     out  1          first mismatch captured
//  err_expected  out  WIDTH      expected value at first mismatch
//  err_got       out  WIDTH      received value at first mismatch
// BEHAVIOUR
//  - Reset: state=SYNC, lfsr=LFSR_SEED, expected=0; all outputs 0 (in_pop 0 while rst high).
//  - in_pop = in_nempty & enable & ~resync & ~rst & throttle_ok (combinational, zero latency); in_data is
//    sampled on the same edge as in_pop. in_pop is never high while in_nempty=0.
//  - throttle_ok = 1 if THROTTLE_BITS==0, else lfsr[THROTTLE_BITS-1:0]==0. The LFSR is 16-bit Galois,
//    mask 16'hB400, shifts every cycle regardless of pop.
//  - FSM SYNC: on pop: expected<=in_data+1, word_count++, ->CHECK. No compare is done.
//  - FSM CHECK: on pop: word_count++. If in_data!=expected: error_count++; if !err_valid, capture
//    err_expected/err_got and set err_valid. In both cases expected<=in_data+1 (re-align after an error,
//    so there is exactly one error per discontinuity).
//  - Arithmetic: expected+1 is truncated to WIDTH, so 2^WIDTH-1 -> 0 is not an error. Counters saturate
//    at all-ones and do not wrap.
//  - resync=1: no pop that cycle; next state SYNC, locked=0 next cycle. err_* and counters are kept.
//  - clear=1: counters and err_valid/err_* are 0 next cycle. A pop in the same cycle is still checked, but it
//    is not counted and not captured (clear wins). clear does not change the FSM state.
//  - enable=0 mid-stream: popping stops; state and expected are held.
//  - rst mid-stream: full reset next cycle, including the LFSR. A pop is not issued in the reset cycle.
//  - locked = (state==CHECK), registered.
// STRUCTURE
//  - Shared header stream_test_defs.vh: FSM state encodings (SYNC=1'b0, CHECK=1'b1), LFSR mask 16'hB400,
//    default LFSR seed.
//  - Sub-module lfsr16 (clk, rst, seed param, q[15:0]), reused by the matching counter source for
//    push throttling.
//  - Top level: FSM, expected register, saturating counters, error capture.
// TESTING
//  1 Reset: rst=1 for 3 cycles with in_nempty=1 -> in_pop=0; all outputs 0; locked=0.
//  2 Clean stream 0..299, THROTTLE_BITS=0, enable=1 -> word_count=300, error_count=0, locked=1 from cycle after
//    first pop, 255->0 wrap gives no error.
//  3 Nonzero seed: stream 0x37,0x38,... (100 words) -> error_count=0 (first word adopted in SYNC).
//  4 Drop: 10,11,13,14,15 then duplicate 15,16 -> error_count=2, err_expected=12, err_got=13, err_valid=1.
//  5 Throttle THROTTLE_BITS=2, in_nempty=1 for 4096 cycles -> pops within 1024+/-128; in_nempty
//    toggled randomly -> in_pop never high while in_nempty=0.
//  6 Mid-stream controls: resync then stream 200,201 -> no error, locked drops for 1+ cycle. clear -> counters 0
//    next cycle. rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fifo_seq_checker_pkg.sv
// Shared definitions for the FIFO stream test blocks: FSM encoding, LFSR polynomial and default seed.
package fifo_seq_checker_pkg;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // One step of the right-shifting 16-bit Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  endfunction

endpackage

// File: rtl/fifo_seq_checker_lfsr16.sv
// Free-running 16-bit Galois LFSR; also used by the matching counter source to throttle pushes.
module lfsr16
  import fifo_seq_checker_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= SEED;
    else     r_q <= lfsr_step(r_q);
  end

  assign q = r_q;

endmodule

// File: rtl/fifo_seq_checker.sv
// Reader side of the FIFO stream test: pops a FWFT FIFO (optionally throttled) and checks that the
// words form a consecutive modulo-2^WIDTH counter, keeping statistics and the first mismatch.
module fifo_seq_checker
  import fifo_seq_checker_pkg::*;
#(
  parameter int          WIDTH         = 8,
  parameter int          CNT_WIDTH     = 32,
  parameter int          THROTTLE_BITS = 2,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 resync,
  input  logic                 clear,
  input  logic                 in_nempty,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_pop,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic                 err_valid,
  output logic [WIDTH-1:0]     err_expected,
  output logic [WIDTH-1:0]     err_got
);

  // Low LFSR bits that must all be zero to allow a pop; an empty mask disables throttling.
  localparam logic [15:0] THR_MASK = 16'((32'd1 << THROTTLE_BITS) - 32'd1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [15:0]          w_lfsr;
  logic                 w_throttle_ok;
  logic                 w_pop;
  logic                 w_mismatch;
  logic [WIDTH-1:0]     w_exp_nxt;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_expected;
  logic [CNT_WIDTH-1:0] r_word_count;
  logic [CNT_WIDTH-1:0] r_error_count;
  logic                 r_err_valid;
  logic [WIDTH-1:0]     r_err_expected;
  logic [WIDTH-1:0]     r_err_got;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  assign w_throttle_ok = ((w_lfsr & THR_MASK) == 16'h0000);
  assign w_pop         = in_nempty & enable & ~resync & ~rst & w_throttle_ok;
  assign w_mismatch    = w_pop & (r_state == ST_CHECK) & (in_data != r_expected);
  assign w_exp_nxt     = in_data + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_SYNC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (resync)
      w_state_nxt = ST_SYNC;
    else if (w_pop && r_state == ST_SYNC)
      w_state_nxt = ST_CHECK;
  end

  // Every popped word re-aligns the expectation, so a discontinuity costs exactly one error.
  always_ff @(posedge clk) begin
    if (rst)        r_expected <= '0;
    else if (w_pop) r_expected <= w_exp_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_word_count  <= '0;
      r_error_count <= '0;
    end else begin
      if (w_pop)      r_word_count  <= sat_inc(r_word_count);
      if (w_mismatch) r_error_count <= sat_inc(r_error_count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_err_valid    <= 1'b0;
      r_err_expected <= '0;
      r_err_got      <= '0;
    end else if (w_mismatch && !r_err_valid) begin
      r_err_valid    <= 1'b1;
      r_err_expected <= r_expected;
      r_err_got      <= in_data;
    end
  end

  assign in_pop       = w_pop;
  assign locked       = (r_state == ST_CHECK);
  assign word_count   = r_word_count;
  assign error_count  = r_error_count;
  assign err_valid    = r_err_valid;
  assign err_expected = r_err_expected;
  assign err_got      = r_err_got;

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Directed bench for fifo_seq_checker: an unthrottled and a throttled instance checked every cycle
// against a behavioural model, plus hand-computed expectations at key points.
module tb_fifo_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1, resync = 1'b0, clear = 1'b0, nempty = 1'b1;
  logic [7:0]  data = 8'd0;
  logic        in_pop, locked, err_valid;
  logic [31:0] word_count, error_count;
  logic [7:0]  err_expected, err_got;

  logic        en2 = 1'b0, nempty2 = 1'b0;
  logic [7:0]  data2 = 8'd0;
  logic        in_pop2, locked2, err_valid2;
  logic [31:0] word_count2, error_count2;
  logic [7:0]  err_expected2, err_got2;

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 0;
  int pops     = 0;

  always #5 clk = ~clk;

  fifo_seq_checker #(.WIDTH(8), .CNT_WIDTH(32), .THROTTLE_BITS(0), .LFSR_SEED(16'hACE1)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .resync(resync), .clear(clear),
    .in_nempty(nempty), .in_data(data), .in_pop(in_pop), .locked(locked),
    .word_count(word_count), .error_count(error_count), .err_valid(err_valid),
    .err_expected(err_expected), .err_got(err_got));

  fifo_seq_checker #(.WIDTH(8), .CNT_WIDTH(32), .THROTTLE_BITS(2), .LFSR_SEED(16'hACE1)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .resync(1'b0), .clear(1'b0),
    .in_nempty(nempty2), .in_data(data2), .in_pop(in_pop2), .locked(locked2),
    .word_count(word_count2), .error_count(error_count2), .err_valid(err_valid2),
    .err_expected(err_expected2), .err_got(err_got2));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: stream rules stated directly with integers.
  logic [15:0] m_lfsr = 16'hACE1;
  bit          m_locked = 0;
  int unsigned m_exp = 0;
  longint      m_wc = 0, m_ec = 0;
  bit          m_errv = 0;
  int unsigned m_erre = 0, m_errg = 0;
  localparam longint CNT_MAX = 64'd4294967295;

  function automatic bit m_pop0();
    return nempty && enable && !resync && !rst;
  endfunction

  function automatic bit m_pop2();
    return nempty2 && en2 && !rst && ((m_lfsr % 4) == 0);
  endfunction

  always @(posedge clk) begin : model
    bit p, mm;
    if (rst) begin
      m_lfsr <= 16'hACE1; m_locked <= 0; m_exp <= 0; m_wc <= 0; m_ec <= 0;
      m_errv <= 0; m_erre <= 0; m_errg <= 0;
    end else begin
      p  = m_pop0();
      mm = p && m_locked && (int'(data) != m_exp);
      if (clear) begin
        m_wc <= 0; m_ec <= 0; m_errv <= 0; m_erre <= 0; m_errg <= 0;
      end else begin
        if (p)  m_wc <= (m_wc < CNT_MAX) ? m_wc + 1 : m_wc;
        if (mm) m_ec <= (m_ec < CNT_MAX) ? m_ec + 1 : m_ec;
        if (mm && !m_errv) begin
          m_errv <= 1; m_erre <= m_exp; m_errg <= int'(data);
        end
      end
      if (p) m_exp <= (int'(data) + 1) % 256;
      if (resync) m_locked <= 0;
      else if (p) m_locked <= 1;
      m_lfsr <= (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 16'hB400) : (m_lfsr / 2);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_pop", in_pop, m_pop0());
      chk("locked", locked, m_locked);
      chk("word_count", word_count, m_wc);
      chk("error_count", error_count, m_ec);
      chk("err_valid", err_valid, m_errv);
      chk("err_expected", err_expected, m_erre);
      chk("err_got", err_got, m_errg);
      chk("in_pop2", in_pop2, m_pop2());
      chk("pop2_when_empty", in_pop2 & ~nempty2, 1'b0);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d);
    nempty = 1'b1; data = d; cyc(); nempty = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    // Reset held three cycles with data available.
    cyc(); started = 1;
    @(negedge clk);
    chk("rst_in_pop", in_pop, 0);
    cyc(); cyc();
    @(negedge clk);
    chk("rst_word_count", word_count, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_model_lfsr", m_lfsr, 16'hACE1);
    rst = 1'b0; nempty = 1'b0;

    // Clean 0..299 including the 255->0 wrap.
    send(8'd0);
    @(negedge clk);
    chk("locked_after_first", locked, 1);
    for (int i = 1; i < 300; i++) send(8'(i));
    @(negedge clk);
    chk("clean_words", word_count, 300);
    chk("clean_errors", error_count, 0);

    // Stream starting at 0x37 adopted in SYNC.
    reset_pulse();
    for (int i = 0; i < 100; i++) send(8'(8'h37 + i));
    @(negedge clk);
    chk("seed37_errors", error_count, 0);
    chk("seed37_words", word_count, 100);

    // Drop and duplicate.
    reset_pulse();
    send(8'd10); send(8'd11); send(8'd13); send(8'd14); send(8'd15); send(8'd15); send(8'd16);
    @(negedge clk);
    chk("drop_errors", error_count, 2);
    chk("drop_err_expected", err_expected, 12);
    chk("drop_err_got", err_got, 13);
    chk("drop_err_valid", err_valid, 1);
    chk("drop_words", word_count, 7);

    // Resync, then jump to 200.
    resync = 1'b1; nempty = 1'b1; data = 8'd99;
    @(negedge clk);
    chk("resync_no_pop", in_pop, 0);
    cyc(); resync = 1'b0; nempty = 1'b0;
    @(negedge clk);
    chk("resync_unlocked", locked, 0);
    send(8'd200); send(8'd201);
    @(negedge clk);
    chk("resync_errors", error_count, 2);
    chk("resync_locked", locked, 1);

    // Clear with a simultaneous pop, then a mismatch after it.
    clear = 1'b1; nempty = 1'b1; data = 8'd202;
    cyc(); clear = 1'b0; nempty = 1'b0;
    @(negedge clk);
    chk("clear_words", word_count, 0);
    chk("clear_errors", error_count, 0);
    chk("clear_err_valid", err_valid, 0);
    send(8'd50);
    @(negedge clk);
    chk("post_clear_errors", error_count, 1);
    chk("post_clear_err_expected", err_expected, 203);
    chk("post_clear_err_got", err_got, 50);

    // enable low holds state and expectation.
    enable = 1'b0; nempty = 1'b1; data = 8'd51;
    repeat (3) cyc();
    enable = 1'b1;
    send(8'd51);
    @(negedge clk);
    chk("hold_errors", error_count, 1);
    chk("hold_words", word_count, 2);

    // Reset mid-stream.
    nempty = 1'b1; data = 8'd52; rst = 1'b1;
    @(negedge clk);
    chk("midrst_no_pop", in_pop, 0);
    cyc(); rst = 1'b0; nempty = 1'b0;
    @(negedge clk);
    chk("midrst_words", word_count, 0);
    chk("midrst_errors", error_count, 0);
    chk("midrst_err_valid", err_valid, 0);
    chk("midrst_locked", locked, 0);

    // Throttled instance: LFSR ACE1 (low bits 01) blocks, then E270 (low bits 00) allows.
    rst = 1'b1; nempty2 = 1'b1; en2 = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("thr_first_blocked", in_pop2, 0);
    cyc();
    @(negedge clk);
    chk("thr_second_pops", in_pop2, 1);
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (in_pop2) pops++;
    end
    chk("thr_rate_in_range", (pops >= 896 && pops <= 1152), 1);
    for (int i = 0; i < 2000; i++) begin
      cyc();
      nempty2 = 1'($urandom_range(0, 1));
    end
    nempty2 = 1'b0; en2 = 1'b0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
